// File: rtl/md_exec_unit_pkg.sv
// Shared constants and types for the multiply/divide execute unit.
// Holds instruction encodings, rstatus codes and the control state encoding.
package md_exec_unit_pkg;

    localparam logic [4:0] OPC_RTYPE  = 5'b00000;
    localparam logic [4:0] ALUOP_MUL  = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    localparam logic [4:0] STATUS_REG = 5'd30;

    localparam int RSTATUS_MUL_OVF = 4;
    localparam int RSTATUS_DIV_EXC = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Two's complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Iterative radix-2 datapath: shift-add multiply and restoring divide on
// operand magnitudes, with the sign fixup and overflow check for the final step.
module md_datapath
    import md_exec_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        div_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [4:0]  cnt,
    output logic [31:0] fin_result,
    output logic        fin_ovf
);

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic        neg;
    logic        is_div;
    logic        div_exc;

    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        fits;
    logic [63:0] mul_add;
    logic [63:0] acc_nxt;
    logic [63:0] prod;
    logic [31:0] quot;

    // Divide keeps {remainder, dividend/quotient} in acc; the shifted
    // remainder needs 33 bits since it can exceed 2^32-1 before subtraction.
    always_comb begin
        rem_sh  = acc[63:31];
        rem_sub = rem_sh - {1'b0, mag_b};
        fits    = (rem_sh >= {1'b0, mag_b});
        mul_add = mag_b[cnt] ? ({32'd0, mag_a} << cnt) : 64'd0;
        if (is_div)
            acc_nxt = {(fits ? rem_sub[31:0] : rem_sh[31:0]), acc[30:0], fits};
        else
            acc_nxt = acc + mul_add;
    end

    always_comb begin
        prod       = neg ? (~acc_nxt + 64'd1) : acc_nxt;
        quot       = neg ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
        fin_result = 32'd0;
        fin_ovf    = 1'b0;
        if (is_div) begin
            fin_result = quot;
            fin_ovf    = div_exc;
        end else begin
            fin_result = prod[31:0];
            fin_ovf    = (prod[63:32] != {32{prod[31]}});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            acc     <= 64'd0;
            neg     <= 1'b0;
            is_div  <= 1'b0;
            div_exc <= 1'b0;
        end else if (load) begin
            mag_a   <= magnitude(a_in);
            mag_b   <= magnitude(b_in);
            acc     <= div_in ? {32'd0, magnitude(a_in)} : 64'd0;
            neg     <= a_in[31] ^ b_in[31];
            is_div  <= div_in;
            div_exc <= div_in && ((b_in == 32'd0) ||
                       (a_in == 32'h8000_0000 && b_in == 32'hFFFF_FFFF));
        end else if (step) begin
            acc     <= acc_nxt;
        end
    end

endmodule

// File: rtl/md_exec_unit.sv
// Multicycle mul/div unit beside the X-stage ALU: FSM, iteration counter,
// front-end stall and the valid/ack result handshake toward XM.
module md_exec_unit
    import md_exec_unit_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MUL_EXC_CODE = RSTATUS_MUL_OVF,
    parameter int DIV_EXC_CODE = RSTATUS_DIV_EXC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       dest_in,
    input  logic             flush,
    input  logic             result_ack,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_dest,
    output logic             exception
);

    md_state_e   state;
    logic [4:0]  cnt;
    logic [4:0]  dest_q;
    logic        op_div;

    logic        start_any;
    logic        launch;
    logic [31:0] fin_result;
    logic        fin_ovf;

    assign start_any = start_mul | start_div;
    // A new op may launch from IDLE, or from DONE in the same cycle as the ack.
    assign launch    = start_any && !flush &&
                       ((state == ST_IDLE) || (state == ST_DONE && result_ack));
    assign stall     = ((state == ST_IDLE) && start_any) || (state == ST_RUN);

    md_datapath u_dp (
        .clock      (clock),
        .reset      (reset),
        .load       (launch),
        .step       (state == ST_RUN),
        .div_in     (!start_mul),
        .a_in       (operand_a),
        .b_in       (operand_b),
        .cnt        (cnt),
        .fin_result (fin_result),
        .fin_ovf    (fin_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 5'd0;
            dest_q       <= 5'd0;
            op_div       <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            result_dest  <= 5'd0;
            exception    <= 1'b0;
        end else if (flush) begin
            state        <= ST_IDLE;
            cnt          <= 5'd0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state  <= ST_RUN;
                        cnt    <= 5'd0;
                        dest_q <= dest_in;
                        op_div <= !start_mul;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        exception    <= fin_ovf;
                        result_dest  <= fin_ovf ? STATUS_REG : dest_q;
                        if (fin_ovf)
                            result <= op_div ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MUL_EXC_CODE);
                        else
                            result <= fin_result;
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        if (launch) begin
                            state  <= ST_RUN;
                            cnt    <= 5'd0;
                            dest_q <= dest_in;
                            op_div <= !start_mul;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_exec_unit.sv
// Scoreboard bench for md_exec_unit: expected results are modelled at issue
// time and compared when result_valid rises.
module tb_md_exec_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_mul = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic [4:0]  dest_in = 5'd0;
    logic        flush = 1'b0;
    logic        result_ack = 1'b0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_dest;
    logic        exception;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;

    md_exec_unit #(.WIDTH(32), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_mul    (start_mul),
        .start_div    (start_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_in      (dest_in),
        .flush        (flush),
        .result_ack   (result_ack),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .result_dest  (result_dest),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d);
        exp_t   e;
        longint sa = $signed(a);
        longint sb_ = $signed(b);
        longint p;
        int     lo;
        e.res  = 32'd0;
        e.dest = d;
        e.exc  = 1'b0;
        if (!is_div) begin
            p     = sa * sb_;
            lo    = int'(p[31:0]);
            e.exc = (p != longint'(lo));
            e.res = p[31:0];
        end else begin
            e.exc = (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            if (!e.exc) e.res = 32'(sa / sb_);
        end
        if (e.exc) begin
            e.res  = is_div ? 32'd5 : 32'd4;
            e.dest = 5'd30;
        end
        return e;
    endfunction

    task automatic drive_start(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] d, input bit push);
        start_mul = !is_div;
        start_div = is_div;
        operand_a = a;
        operand_b = b;
        dest_in   = d;
        if (push) sb.push_back(model(is_div, a, b, d));
    endtask

    // Called in the cycle the start is driven (cycle 0); expects valid at cycle 33.
    task automatic await_result(input string tag, input bit stall0);
        int cyc = 0;
        bit gap = 0;
        @(negedge clock);
        chk({tag, " stall c0"}, stall, stall0);
        @(posedge clock); #1;
        start_mul = 0; start_div = 0; result_ack = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (result_valid) begin cyc = c; break; end
            if (!stall) gap = 1;
        end
        chk({tag, " latency"}, cyc, 33);
        chk({tag, " stall run"}, gap, 0);
        chk({tag, " stall done"}, stall, 0);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard"}, 1, 0);
        end else begin
            cur = sb.pop_front();
            chk({tag, " result"}, result, cur.res);
            chk({tag, " dest"}, result_dest, cur.dest);
            chk({tag, " exc"}, exception, cur.exc);
        end
    endtask

    task automatic do_ack();
        @(posedge clock); #1 result_ack = 1;
        @(posedge clock); #1 result_ack = 0;
        @(negedge clock);
        chk("ack clears valid", result_valid, 0);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clock);
            if (result_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst valid", result_valid, 0);
        chk("rst result", result, 0);
        chk("rst dest", result_dest, 0);
        chk("rst exc", exception, 0);
        chk("rst stall", stall, 0);
        @(posedge clock); #1 reset = 0;

        @(posedge clock); #1 drive_start(0, 32'd7, -32'sd6, 5'd3, 1);
        await_result("mul 7x-6", 1);
        repeat (3) begin
            @(negedge clock);
            chk("hold valid", result_valid, 1);
            chk("hold result", result, cur.res);
            chk("hold dest", result_dest, cur.dest);
        end
        do_ack();

        @(posedge clock); #1 drive_start(0, 32'h0001_0000, 32'h0001_0000, 5'd4, 1);
        await_result("mul ovf", 1);
        do_ack();

        @(posedge clock); #1 drive_start(1, -32'sd7, 32'd2, 5'd5, 1);
        await_result("div -7/2", 1);
        do_ack();
        @(posedge clock); #1 drive_start(1, 32'd5, 32'd0, 5'd6, 1);
        await_result("div by 0", 1);
        do_ack();
        @(posedge clock); #1 drive_start(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1);
        await_result("div ovf", 1);

        // Ack in the same cycle as the next start launches straight into RUN.
        @(posedge clock); #1 result_ack = 1;
        drive_start(1, 32'd100, -32'sd7, 5'd9, 1);
        await_result("ack+div", 0);
        do_ack();

        // Both starts high: mul wins.
        @(posedge clock); #1 drive_start(0, 32'h8000_0000, 32'd1, 5'd11, 1);
        start_div = 1;
        await_result("mul prio", 1);
        do_ack();

        // Flush at cycle 10 of a mul.
        @(posedge clock); #1 drive_start(0, 32'd9, 32'd9, 5'd2, 0);
        @(negedge clock);
        @(posedge clock); #1 start_mul = 0;
        repeat (9) @(posedge clock);
        #1 flush = 1;
        @(posedge clock); #1 flush = 0;
        @(negedge clock);
        chk("flush stall c11", stall, 0);
        watch_no_valid("flush no valid", 40);

        // Flush together with a start in IDLE ignores the start.
        @(posedge clock); #1 flush = 1;
        drive_start(0, 32'd3, 32'd3, 5'd1, 0);
        @(posedge clock); #1 flush = 0; start_mul = 0;
        @(negedge clock);
        chk("flush+start stall", stall, 0);
        watch_no_valid("flush+start no valid", 40);

        // Asynchronous reset at cycle 15 of a div.
        @(posedge clock); #1 drive_start(1, 32'd1000, 32'd3, 5'd8, 0);
        @(negedge clock);
        @(posedge clock); #1 start_div = 0;
        repeat (14) @(posedge clock);
        #2 reset = 1;
        #1;
        chk("midrst valid", result_valid, 0);
        chk("midrst result", result, 0);
        chk("midrst dest", result_dest, 0);
        chk("midrst exc", exception, 0);
        chk("midrst stall", stall, 0);
        @(posedge clock); #1 reset = 0;
        @(posedge clock); #1 drive_start(0, -32'sd3, 32'd5, 5'd12, 1);
        await_result("mul after rst", 1);
        do_ack();

        for (int i = 0; i < 6; i++) begin
            bit          op = i[0];
            logic [31:0] a  = $urandom;
            logic [31:0] b  = (i < 2) ? 32'($urandom_range(0, 65535)) : $urandom;
            if (i >= 4) a = 32'($urandom_range(0, 4000)) - 32'd2000;
            @(posedge clock); #1 drive_start(op, a, b, 5'($urandom_range(1, 29)), 1);
            await_result("rand", 1);
            do_ack();
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
